rib_uart_tx: RTL and testbench

Memory-mapped UART transmitter that sits as a responder on the core's RIB data bus, on the other end of the core's ex-stage request interface (addr/data/req/we). The core writes bytes into a small TX FIFO through zero-wait-state register writes. A serialiser FSM then shifts each byte out on a single pin as 8N1 (optionally 8E1/8O1) at a programmable baud rate. A level interrupt feeds one bit of the core's `int_i`.

---
 rtl/rib_uart_pkg.sv | 32 +++
 rtl/rib_uart_fifo.sv | 53 +++++
 rtl/rib_uart_tx.sv | 187 ++++++++++++++++++
 tb/tb_rib_uart_tx.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rib_uart_pkg.sv
// rib_uart_pkg: shared constants and types for the RIB UART transmitter.
// RIB_UART_PARITY_EN adds the PARITY state to the FSM enum.
package rib_uart_pkg;

  localparam int BAUD_W = 16;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_BAUD   = 2'd2;
  localparam logic [1:0] REG_TXDATA = 2'd3;

  localparam int CTRL_TX_EN  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_P_ODD  = 2;

  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_LVL   = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef RIB_UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

endpackage

// File: rtl/rib_uart_fifo.sv
// rib_uart_fifo: byte FIFO with wrapping extra-bit pointers.
// Pushes while full are ignored; the caller tracks overflow.
module rib_uart_fifo
  import rib_uart_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [7:0]   data_i,
  input  logic         pop_i,
  output logic [7:0]   data_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [PW:0]  level_o
);

  logic [7:0]  mem_q [DEPTH];
  logic [PW:0] wr_q;
  logic [PW:0] rd_q;
  logic        push;
  logic        pop;

  assign level_o = wr_q - rd_q;
  assign full_o  = (level_o == (PW+1)'(DEPTH));
  assign empty_o = (level_o == '0);
  assign push    = push_i & ~full_o;
  assign pop     = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_q[PW-1:0]];

  // Pointer update; reset discards any queued bytes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // Storage write on accepted push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_q[PW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/rib_uart_tx.sv
// rib_uart_tx: RIB-mapped UART transmitter, 8N1 with programmable baud.
// Define RIB_UART_PARITY_EN for 8E1/8O1 framing.
module rib_uart_tx
  import rib_uart_pkg::*;
#(
  parameter int                FIFO_DEPTH = 8,
  parameter logic [BAUD_W-1:0] BAUD_RESET = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        tx_o,
  output logic        int_o
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [2:0]        ctrl_q, ctrl_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic              ovf_q, ovf_d;
  state_e            state_q, state_d;
  logic [7:0]        shift_q, shift_d;
  logic [2:0]        bit_q, bit_d;
  logic [BAUD_W-1:0] cnt_q, cnt_d;
  logic              par_q, par_d;

  logic [1:0]        idx;
  logic              wr;
  logic              rd;
  logic              push_req;
  logic              pop;
  logic [7:0]        head;
  logic              full;
  logic              empty;
  logic [PW:0]       level;
  logic              busy;
  logic              can_pop;
  logic              bit_end;
  logic [BAUD_W-1:0] per_m1;
  logic              unused_bits;

  assign idx      = addr_i[3:2];
  assign wr       = req_i & we_i;
  assign rd       = req_i & ~we_i;
  assign push_req = wr & (idx == REG_TXDATA);
  assign busy     = (state_q != S_IDLE);
  assign can_pop  = ctrl_q[CTRL_TX_EN] & ~empty;
  assign bit_end  = (cnt_q == '0);
  assign per_m1   = (baud_q == '0) ? '0 : baud_q - 1'b1;
  assign int_o    = ctrl_q[CTRL_IRQ_EN] & empty & ~busy;

  assign unused_bits = ^{addr_i[31:4], addr_i[1:0], data_i[31:16]};

  rib_uart_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_req),
    .data_i  (data_i[7:0]),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  // Register file next state from bus writes.
  always_comb begin
    ctrl_d = ctrl_q;
    baud_d = baud_q;
    ovf_d  = ovf_q;
    if (wr && idx == REG_CTRL) begin
      ctrl_d = data_i[2:0];
`ifndef RIB_UART_PARITY_EN
      ctrl_d[CTRL_P_ODD] = 1'b0;
`endif
    end
    if (wr && idx == REG_BAUD) baud_d = data_i[BAUD_W-1:0];
    if (wr && idx == REG_STATUS && data_i[ST_OVF]) ovf_d = 1'b0;
    if (push_req && full) ovf_d = 1'b1;
  end

  // Combinational read mux, zero outside read cycles.
  always_comb begin
    data_o = '0;
    if (rd) begin
      unique case (idx)
        REG_CTRL:   data_o = {29'd0, ctrl_q};
        REG_STATUS: data_o = {23'd0, 5'(level), ovf_q,
                              empty, full, busy};
        REG_BAUD:   data_o = {16'd0, baud_q};
        default:    data_o = '0;
      endcase
    end
  end

  // Serialiser next state, pop request and line level.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    cnt_d   = bit_end ? per_m1 : cnt_q - 1'b1;
    par_d   = par_q;
    pop     = 1'b0;
    tx_o    = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = cnt_q;
        if (can_pop) begin
          pop     = 1'b1;
          shift_d = head;
          par_d   = ^head ^ ctrl_q[CTRL_P_ODD];
          bit_d   = '0;
          cnt_d   = per_m1;
          state_d = S_START;
        end
      end
      S_START: begin
        tx_o = 1'b0;
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        tx_o = shift_q[0];
        if (bit_end) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
`ifdef RIB_UART_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef RIB_UART_PARITY_EN
      S_PARITY: begin
        tx_o = par_q;
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (can_pop) begin
            pop     = 1'b1;
            shift_d = head;
            par_d   = ^head ^ ctrl_q[CTRL_P_ODD];
            bit_d   = '0;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and register update; reset aborts any frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q  <= '0;
      baud_q  <= BAUD_RESET;
      ovf_q   <= 1'b0;
      state_q <= S_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      baud_q  <= baud_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
    end
  end

endmodule

// File: tb/tb_rib_uart_tx.sv
// tb_rib_uart_tx: register table, frame waveform model, random frames.
// Follows RIB_UART_PARITY_EN to choose 10- or 11-bit frames.
module tb_rib_uart_tx;

  localparam int DEPTH = 8;
`ifdef RIB_UART_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        tx;
  logic        irq;

  int ncmp = 0;
  int nfail = 0;
  logic [31:0] wr_seen;

  rib_uart_tx #(
    .FIFO_DEPTH (DEPTH),
    .BAUD_RESET (16'd434)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req_i  (req),
    .we_i   (we),
    .addr_i (addr),
    .data_i (wdata),
    .data_o (rdata),
    .tx_o   (tx),
    .int_o  (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  typedef struct {
    logic        w;
    logic [1:0]  r;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [1:0] r, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = 1'b1;
    addr = {28'd0, r, 2'b00}; wdata = d;
    #1 wr_seen = rdata;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] r, output logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = 1'b0;
    addr = {28'd0, r, 2'b00};
    #1 d = rdata;
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic rd_chk(input logic [1:0] r, input logic [31:0] exp,
                        input string nm);
    logic [31:0] v;
    bus_rd(r, v);
    check(nm, v, exp);
  endtask

  // Expected line: per frame 0, d0..d7, [parity], 1; each held per cycles.
  task automatic expect_stream(input logic [7:0] q[$], input int per,
                               input logic podd, input string nm);
    logic exp[$];
    int err = 0;
    foreach (q[i]) begin
      logic [7:0] b;
      logic bits[$];
      b = q[i];
      bits.push_back(1'b0);
      for (int j = 0; j < 8; j++) bits.push_back(b[j]);
      if (PAR) bits.push_back((^b) ^ podd);
      bits.push_back(1'b1);
      foreach (bits[k])
        for (int c = 0; c < per; c++) exp.push_back(bits[k]);
    end
    foreach (exp[k]) begin
      @(posedge clk); #1;
      if (tx !== exp[k]) err++;
    end
    check(nm, err, 0);
  endtask

  vec_t vecs[15];
  logic [7:0] bq[$];

  initial begin
    vecs[0]  = '{1'b0, 2'd0, 32'h0, 32'h0};
    vecs[1]  = '{1'b0, 2'd1, 32'h0, 32'h4};
    vecs[2]  = '{1'b0, 2'd2, 32'h0, 32'd434};
    vecs[3]  = '{1'b0, 2'd3, 32'h0, 32'h0};
    vecs[4]  = '{1'b1, 2'd2, 32'hABCD1234, 32'h0};
    vecs[5]  = '{1'b0, 2'd2, 32'h0, 32'h1234};
    vecs[6]  = '{1'b1, 2'd0, 32'hFFFFFFF8, 32'h0};
    vecs[7]  = '{1'b0, 2'd0, 32'h0, 32'h0};
    vecs[8]  = '{1'b1, 2'd0, 32'h5, 32'h0};
    vecs[9]  = '{1'b0, 2'd0, 32'h0, PAR ? 32'h5 : 32'h1};
    vecs[10] = '{1'b1, 2'd0, 32'h0, 32'h0};
    vecs[11] = '{1'b1, 2'd1, 32'hFFFFFFFF, 32'h0};
    vecs[12] = '{1'b0, 2'd1, 32'h0, 32'h4};
    vecs[13] = '{1'b1, 2'd2, 32'h0, 32'h0};
    vecs[14] = '{1'b0, 2'd2, 32'h0, 32'h0};

    #22 rst = 1'b1;
    #1;
    check("reset tx", tx, 1);
    check("reset int", irq, 0);
    check("reset data_o", rdata, 0);

    foreach (vecs[i]) begin
      if (vecs[i].w) begin
        bus_wr(vecs[i].r, vecs[i].d);
        check($sformatf("vec%0d wr data_o", i), wr_seen, vecs[i].exp);
      end else begin
        rd_chk(vecs[i].r, vecs[i].exp, $sformatf("vec%0d rd", i));
      end
    end

    // Single 0xA5 frame at 4 cycles per bit.
    bus_wr(2'd2, 32'd4);
    bus_wr(2'd0, 32'h1);
    bus_wr(2'd3, 32'hA5);
    check("a5 tx before pop", tx, 1);
    bq = '{8'hA5};
    expect_stream(bq, 4, 1'b0, "a5 frame");
    rd_chk(2'd1, 32'h5, "a5 busy in stop");
    rd_chk(2'd1, 32'h4, "a5 idle after");

    // Overfill, clear overflow, then drain back-to-back.
    bus_wr(2'd2, 32'd2);
    bus_wr(2'd0, 32'h0);
    bq.delete();
    for (int i = 0; i <= DEPTH; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      if (bq.size() < DEPTH) bq.push_back(b);
      bus_wr(2'd3, {24'd0, b});
    end
    rd_chk(2'd1, 32'h8A, "full ovf level8");
    bus_wr(2'd1, 32'h8);
    rd_chk(2'd1, 32'h82, "ovf cleared");
    bus_wr(2'd0, 32'h1);
    expect_stream(bq, 2, 1'b0, "8 frames b2b");
    @(posedge clk);
    rd_chk(2'd1, 32'h4, "drained");

    // Interrupt low while a frame is in flight.
    bus_wr(2'd0, 32'h3);
    check("int empty idle", irq, 1);
    bus_wr(2'd3, 32'h3C);
    check("int after push", irq, 0);
    begin
      int err = 0;
      for (int k = 0; k < (PAR ? 11 : 10) * 2; k++) begin
        @(posedge clk); #1;
        if (irq !== 1'b0) err++;
      end
      check("int low in frame", err, 0);
    end
    @(posedge clk); #1;
    check("int after stop", irq, 1);

    // Odd parity on 0x03 (plain 10-bit frame without parity).
    bus_wr(2'd0, 32'h5);
    bus_wr(2'd3, 32'h03);
    bq = '{8'h03};
    expect_stream(bq, 2, 1'b1, "0x03 odd frame");
    @(posedge clk);

    // Random bytes, baud 0..3 (0 behaves as 1), random parity sense.
    for (int it = 0; it < 6; it++) begin
      int bv;
      int n;
      logic podd;
      bv = $urandom_range(0, 3);
      n = $urandom_range(1, 3);
      podd = 1'($urandom_range(0, 1));
      bus_wr(2'd2, bv);
      bus_wr(2'd0, {29'd0, podd, 2'b00});
      bq.delete();
      for (int i = 0; i < n; i++) begin
        bq.push_back(8'($urandom));
        bus_wr(2'd3, {24'd0, bq[i]});
      end
      bus_wr(2'd0, {29'd0, podd, 2'b01});
      expect_stream(bq, (bv == 0) ? 1 : bv, podd,
                    $sformatf("rand%0d baud%0d", it, bv));
      @(posedge clk);
      rd_chk(2'd1, 32'h4, $sformatf("rand%0d idle", it));
    end

    // Reset mid-DATA with one byte still queued.
    bus_wr(2'd2, 32'd4);
    bus_wr(2'd0, 32'h1);
    bus_wr(2'd3, 32'h00);
    bus_wr(2'd3, 32'h55);
    repeat (8) @(posedge clk);
    #1 check("tx low in data", tx, 0);
    #2 rst = 1'b0;
    #1 check("tx high in reset", tx, 1);
    @(negedge clk) rst = 1'b1;
    rd_chk(2'd1, 32'h4, "status after reset");
    rd_chk(2'd0, 32'h0, "ctrl after reset");
    rd_chk(2'd2, 32'd434, "baud after reset");
    check("tx idle after reset", tx, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
